// File: rtl/inst_stream_loader_pkg.sv
// Shared types and constants for the instruction-RAM stream loader.
// Holds the loader state encoding, the default frame marker and the RAM depth.
package inst_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } ld_state_t;

    localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
    localparam int         IMEM_WORDS   = 128;

endpackage

// File: rtl/inst_word_packer.sv
// Packs a byte stream into 32-bit words, first byte landing in the MSB.
// word_valid/word are combinational so the caller can register the word on the 4th-byte edge.
module inst_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    // Only the first three bytes need storing; the fourth arrives with word_valid.
    logic [23:0] shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= 2'd0;
            shreg    <= 24'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            shreg    <= 24'd0;
        end else if (shift_en) begin
            byte_idx <= byte_idx + 2'd1;
            shreg    <= {shreg[15:0], byte_in};
        end
    end

    assign word_valid = shift_en && (byte_idx == 2'd3);
    assign word       = {shreg, byte_in};

endmodule

// File: rtl/inst_stream_loader.sv
// Byte-serial program image loader driving the instruction-RAM load port.
// Frame: HDR, LEN, 4*N payload bytes, CSUM (XOR of LEN and payload); IWEN holds the core until done.
module inst_stream_loader
    import inst_stream_loader_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE  = DEF_HDR_BYTE,
    parameter int         ADDR_W    = 7,
    parameter int         DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              IWEN,
    output logic [ADDR_W-1:0] I_Addr,
    output logic [31:0]       wInst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    localparam int WCNT_W = ADDR_W + 1;
    localparam int DCNT_W = $clog2(DRAIN_CYC + 1);

    // Handshake: a byte transfers on every rising edge where byte_valid && byte_ready;
    // byte_data must be stable while byte_valid is high, and byte_ready never depends on byte_valid.

    ld_state_t           state_q, state_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WCNT_W-1:0]   word_idx_q, word_idx_d;
    logic [WCNT_W-1:0]   word_idx_inc;
    logic [7:0]          csum_q, csum_d;
    logic [DCNT_W-1:0]   drain_q, drain_d;
    logic                iwen_d, busy_d, done_d, err_d, ready_d;
    logic [ADDR_W-1:0]   iaddr_d;
    logic [31:0]         winst_d;

    logic                accept;
    logic                pk_clear, pk_shift, pk_word_valid;
    logic [31:0]         pk_word;

    assign accept       = byte_valid && byte_ready;
    assign pk_clear     = accept && (state_q == ST_LEN);
    assign pk_shift     = accept && (state_q == ST_DATA);
    assign word_idx_inc = word_idx_q + WCNT_W'(1);
    assign state_dbg    = state_q;

    inst_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .shift_en   (pk_shift),
        .byte_in    (byte_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        drain_d    = drain_q;
        iwen_d     = IWEN;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;
        iaddr_d    = I_Addr;
        winst_d    = wInst;

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (accept && (byte_data == HDR_BYTE)) begin
                    state_d = ST_LEN;
                    iwen_d  = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    // LEN of zero encodes a full-RAM image.
                    word_cnt_d = (byte_data == 8'd0) ? WCNT_W'(IMEM_WORDS) : WCNT_W'(byte_data);
                    word_idx_d = '0;
                    csum_d     = byte_data;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_data;
                    if (pk_word_valid) begin
                        winst_d    = pk_word;
                        iaddr_d    = word_idx_q[ADDR_W-1:0];
                        word_idx_d = word_idx_inc;
                        if (word_idx_inc == word_cnt_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (byte_data == csum_q) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                // Keep IWEN up long enough for the RAM to commit the final word.
                if (drain_q == DCNT_W'(DRAIN_CYC - 1)) begin
                    state_d = ST_IDLE;
                    iwen_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                iwen_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        ready_d = (state_d != ST_DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            csum_q     <= 8'd0;
            drain_q    <= '0;
            IWEN       <= 1'b0;
            I_Addr     <= '0;
            wInst      <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_ready <= 1'b1;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            drain_q    <= drain_d;
            IWEN       <= iwen_d;
            I_Addr     <= iaddr_d;
            wInst      <= winst_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            byte_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_inst_stream_loader.sv
// Directed bench for inst_stream_loader: one task per scenario with inline checks.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_inst_stream_loader;
    import inst_stream_loader_pkg::*;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        IWEN;
    logic [6:0]  I_Addr;
    logic [31:0] wInst;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    inst_stream_loader dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .IWEN       (IWEN),
        .I_Addr     (I_Addr),
        .wInst      (wInst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    // byte_valid is left high so consecutive calls stream back-to-back.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!byte_ready) begin
            errors++;
            $display("FAIL send_byte_timeout: byte_ready=%0b required=1", byte_ready);
        end
        @(negedge clk);
    endtask

    task automatic stop_bytes();
        byte_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Counts falling edges after a checksum accept until done is seen; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({IWEN, I_Addr, wInst, busy, done, err, byte_ready} !== {1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: IWEN=%0b I_Addr=%h wInst=%h busy=%0b done=%0b err=%0b ready=%0b required 0/00/00000000/0/0/0/1",
                     IWEN, I_Addr, wInst, busy, done, err, byte_ready);
        end
        checks++;
        if (state_dbg !== 3'(ST_IDLE)) begin
            errors++;
            $display("FAIL reset_state: state=%0d required=%0d", state_dbg, 3'(ST_IDLE));
        end
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_single_word();
        int cyc;
        send_byte(8'hA5);
        checks++;
        if (IWEN !== 1'b1 || busy !== 1'b1 || state_dbg !== 3'(ST_LEN)) begin
            errors++;
            $display("FAIL single_hdr: IWEN=%0b busy=%0b state=%0d required 1/1/%0d", IWEN, busy, state_dbg, 3'(ST_LEN));
        end
        send_byte(8'h01);
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'hA0);
        checks++;
        if (wInst !== 32'd0) begin
            errors++;
            $display("FAIL single_no_early_write: wInst=%h required=00000000", wInst);
        end
        send_byte(8'h00);
        checks++;
        if (wInst !== 32'h1305A000 || I_Addr !== 7'd0) begin
            errors++;
            $display("FAIL single_word: wInst=%h I_Addr=%h required 1305a000/00", wInst, I_Addr);
        end
        send_byte(8'hB7);
        stop_bytes();
        checks++;
        if (byte_ready !== 1'b0 || IWEN !== 1'b1 || state_dbg !== 3'(ST_DRAIN)) begin
            errors++;
            $display("FAIL single_drain_entry: ready=%0b IWEN=%0b state=%0d required 0/1/%0d", byte_ready, IWEN, state_dbg, 3'(ST_DRAIN));
        end
        wait_done(cyc);
        checks++;
        if (cyc != 2 || IWEN !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_done: cycles=%0d IWEN=%0b busy=%0b err=%0b required 2/0/0/0", cyc, IWEN, busy, err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || byte_ready !== 1'b1 || state_dbg !== 3'(ST_IDLE)) begin
            errors++;
            $display("FAIL single_done_pulse: done=%0b ready=%0b state=%0d required 0/1/%0d", done, byte_ready, state_dbg, 3'(ST_IDLE));
        end
    endtask

    task automatic test_bad_checksum();
        int cyc;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h13);
        send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'hB6);
        stop_bytes();
        checks++;
        if (err !== 1'b1 || IWEN !== 1'b1 || busy !== 1'b0 || state_dbg !== 3'(ST_ERR)) begin
            errors++;
            $display("FAIL bad_csum: err=%0b IWEN=%0b busy=%0b state=%0d required 1/1/0/%0d", err, IWEN, busy, state_dbg, 3'(ST_ERR));
        end
        idle_cycles(5);
        send_byte(8'h01);
        stop_bytes();
        checks++;
        if (err !== 1'b1 || IWEN !== 1'b1 || done !== 1'b0 || state_dbg !== 3'(ST_ERR)) begin
            errors++;
            $display("FAIL err_sticky: err=%0b IWEN=%0b done=%0b state=%0d required 1/1/0/%0d", err, IWEN, done, state_dbg, 3'(ST_ERR));
        end
        send_byte(8'hA5);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || state_dbg !== 3'(ST_LEN)) begin
            errors++;
            $display("FAIL err_clear_on_hdr: err=%0b busy=%0b state=%0d required 0/1/%0d", err, busy, state_dbg, 3'(ST_LEN));
        end
        send_byte(8'h01); send_byte(8'h13); send_byte(8'h05);
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'hB7);
        stop_bytes();
        wait_done(cyc);
        checks++;
        if (cyc != 2 || IWEN !== 1'b0 || err !== 1'b0 || wInst !== 32'h1305A000) begin
            errors++;
            $display("FAIL recover_load: cycles=%0d IWEN=%0b err=%0b wInst=%h required 2/0/0/1305a000", cyc, IWEN, err, wInst);
        end
        @(negedge clk);
    endtask

    task automatic test_full_image();
        int cyc;
        int bad;
        bad = 0;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int k = 0; k < 128; k++) begin
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'(k));
            checks++;
            if (wInst !== 32'(k) || I_Addr !== 7'(k)) begin
                errors++;
                if (bad < 5) $display("FAIL full_word_%0d: wInst=%h I_Addr=%h required %h/%h", k, wInst, I_Addr, 32'(k), 7'(k));
                bad++;
            end
        end
        checks++;
        if (state_dbg !== 3'(ST_CSUM) || IWEN !== 1'b1) begin
            errors++;
            $display("FAIL full_csum_state: state=%0d IWEN=%0b required %0d/1", state_dbg, IWEN, 3'(ST_CSUM));
        end
        send_byte(8'h00);
        stop_bytes();
        wait_done(cyc);
        checks++;
        if (cyc != 2 || I_Addr !== 7'h7F || wInst !== 32'h0000007F || err !== 1'b0) begin
            errors++;
            $display("FAIL full_done: cycles=%0d I_Addr=%h wInst=%h err=%0b required 2/7f/0000007f/0", cyc, I_Addr, wInst, err);
        end
        @(negedge clk);
    endtask

    task automatic test_junk_idle();
        int cyc;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        stop_bytes();
        checks++;
        if (IWEN !== 1'b0 || busy !== 1'b0 || I_Addr !== 7'h7F || wInst !== 32'h0000007F || state_dbg !== 3'(ST_IDLE)) begin
            errors++;
            $display("FAIL junk_ignored: IWEN=%0b busy=%0b I_Addr=%h wInst=%h state=%0d required 0/0/7f/0000007f/%0d",
                     IWEN, busy, I_Addr, wInst, state_dbg, 3'(ST_IDLE));
        end
        send_byte(8'hA5);
        checks++;
        if (IWEN !== 1'b1 || state_dbg !== 3'(ST_LEN)) begin
            errors++;
            $display("FAIL junk_then_hdr: IWEN=%0b state=%0d required 1/%0d", IWEN, state_dbg, 3'(ST_LEN));
        end
        // Header value appears as payload here and must be treated as data.
        send_byte(8'h01); send_byte(8'hA5); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'hA4);
        stop_bytes();
        wait_done(cyc);
        checks++;
        if (cyc != 2 || wInst !== 32'hA5112233 || I_Addr !== 7'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL hdr_as_data: cycles=%0d wInst=%h I_Addr=%h err=%0b required 2/a5112233/00/0", cyc, wInst, I_Addr, err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_data();
        int cyc;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h13); send_byte(8'h05);
        stop_bytes();
        checks++;
        if (IWEN !== 1'b1 || state_dbg !== 3'(ST_DATA)) begin
            errors++;
            $display("FAIL pre_reset: IWEN=%0b state=%0d required 1/%0d", IWEN, state_dbg, 3'(ST_DATA));
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (IWEN !== 1'b0 || busy !== 1'b0 || I_Addr !== 7'd0 || wInst !== 32'd0 || byte_ready !== 1'b1 || state_dbg !== 3'(ST_IDLE)) begin
            errors++;
            $display("FAIL async_reset: IWEN=%0b busy=%0b I_Addr=%h wInst=%h ready=%0b state=%0d required 0/0/00/00000000/1/%0d",
                     IWEN, busy, I_Addr, wInst, byte_ready, state_dbg, 3'(ST_IDLE));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h13);
        send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00); send_byte(8'hB7);
        stop_bytes();
        wait_done(cyc);
        checks++;
        if (cyc != 2 || wInst !== 32'h1305A000 || I_Addr !== 7'd0 || IWEN !== 1'b0) begin
            errors++;
            $display("FAIL reload_after_reset: cycles=%0d wInst=%h I_Addr=%h IWEN=%0b required 2/1305a000/00/0", cyc, wInst, I_Addr, IWEN);
        end
        @(negedge clk);
    endtask

    task automatic test_throttled();
        int cyc;
        logic [7:0] frame [7];
        frame = '{8'hA5, 8'h01, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        // Clear wInst first so the final value must come from this frame.
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            send_byte(frame[i]);
            stop_bytes();
            if (i < 6) begin
                idle_cycles(3);
                checks++;
                if (IWEN !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL throttle_gap_%0d: IWEN=%0b done=%0b required 1/0", i, IWEN, done);
                end
            end
        end
        wait_done(cyc);
        checks++;
        if (cyc != 2 || wInst !== 32'h1305A000 || I_Addr !== 7'd0 || err !== 1'b0 || IWEN !== 1'b0) begin
            errors++;
            $display("FAIL throttled_load: cycles=%0d wInst=%h I_Addr=%h err=%0b IWEN=%0b required 2/1305a000/00/0/0",
                     cyc, wInst, I_Addr, err, IWEN);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bad_checksum();
        test_full_image();
        test_junk_idle();
        test_reset_mid_data();
        test_throttled();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
